// File: rtl/sl_pkg.sv
// Shared same-latency (SL) tree types: request/response beats and the
// read-tracker entry used by the root arbiter.
package sl_pkg;

  localparam int unsigned SL_AW        = 16;
  localparam int unsigned SL_DW        = 32;
  localparam int unsigned SL_NUM_M_MAX = 16;
  localparam int unsigned SL_IDXW      = $clog2(SL_NUM_M_MAX);

  typedef struct packed {
    logic             wen;
    logic [SL_AW-1:0] waddr;
    logic [SL_DW-1:0] wdata;
  } SL_WREQ;

  typedef struct packed {
    logic             ren;
    logic [SL_AW-1:0] raddr;
  } SL_RREQ;

  typedef struct packed {
    SL_WREQ wreq;
    SL_RREQ rreq;
  } SL_REQ;

  typedef struct packed {
    logic             rvalid;
    logic [SL_DW-1:0] rdata;
  } SL_RES;

  // Tracker slot: which master issued the read occupying this pipe stage.
  typedef struct packed {
    logic               valid;
    logic [SL_IDXW-1:0] idx;
  } SL_RTAG;

endpackage

// File: rtl/sl_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant starting the search at
// an internal pointer, which advances past the winner on each grant.
module sl_rr_arb #(
  parameter int unsigned NUM_M = 4,
  localparam int unsigned IDW  = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_M-1:0] i_req,
  output logic [NUM_M-1:0] o_gnt,
  output logic [IDW-1:0]   o_idx,
  output logic             o_any
);

  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   w_idx;
  logic             w_any;
  logic [NUM_M-1:0] w_gnt;
  int unsigned      w_best;
  int unsigned      w_dist;

  // Winner is the requester with the smallest modulo distance from r_ptr.
  always_comb begin
    w_idx  = '0;
    w_any  = 1'b0;
    w_gnt  = '0;
    w_best = NUM_M;
    w_dist = 0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (i_req[i]) begin
        w_dist = (i >= 32'(r_ptr)) ? (i - 32'(r_ptr)) : (i + NUM_M - 32'(r_ptr));
        if (w_dist < w_best) begin
          w_best = w_dist;
          w_idx  = IDW'(i);
          w_any  = 1'b1;
        end
      end
    end
    for (int unsigned i = 0; i < NUM_M; i++) begin
      w_gnt[i] = w_any && (w_idx == IDW'(i));
    end
    if (rst) begin
      w_gnt = '0;
      w_any = 1'b0;
    end
  end

  assign o_gnt = w_gnt;
  assign o_idx = w_idx;
  assign o_any = w_any;

  // Pointer moves to the slot after the winner; holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= (w_idx == IDW'(NUM_M - 1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

// File: rtl/sl_root_arbiter.sv
// Root-port arbiter for an SL request tree: independent RR write and read
// grants merged into one registered beat, plus a fixed-depth read-tag pipe
// that steers the fixed-latency response back to the issuing master.
module sl_root_arbiter
  import sl_pkg::*;
#(
  parameter int unsigned NUM_M  = 4,
  parameter int unsigned RD_LAT = 6
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_M*$bits(SL_REQ)-1:0]  req_m,
  output logic [NUM_M-1:0]                gnt_w,
  output logic [NUM_M-1:0]                gnt_r,
  output logic [NUM_M*$bits(SL_RES)-1:0]  res_m,
  output logic [$bits(SL_REQ)-1:0]        req_root,
  input  logic [$bits(SL_RES)-1:0]        res_root,
  output logic [$clog2(RD_LAT+1)-1:0]     rd_outstanding,
  output logic                            lat_err
);

  localparam int unsigned IDW = $clog2(NUM_M);
  localparam int unsigned RW  = $bits(SL_REQ);
  localparam int unsigned SW  = $bits(SL_RES);
  localparam int unsigned CW  = $clog2(RD_LAT + 1);

  SL_REQ            w_req [NUM_M];
  logic [NUM_M-1:0] w_wv;
  logic [NUM_M-1:0] w_rv;
  logic [IDW-1:0]   w_widx;
  logic [IDW-1:0]   w_ridx;
  logic             w_wany;
  logic             w_rany;
  SL_REQ            w_root;
  SL_RES            w_res;
  SL_RTAG           w_tail;
  logic             w_deliver;

  SL_REQ            r_root;
  SL_RES            r_res [NUM_M];
  SL_RTAG           r_tag [0:RD_LAT];
  logic [CW-1:0]    r_cnt;
  logic             r_err;

  // Unpack per-master requests and extract the valid bits.
  always_comb begin
    for (int unsigned i = 0; i < NUM_M; i++) begin
      w_req[i] = SL_REQ'(req_m[i*RW +: RW]);
      w_wv[i]  = w_req[i].wreq.wen;
      w_rv[i]  = w_req[i].rreq.ren;
    end
  end

  sl_rr_arb #(.NUM_M(NUM_M)) u_warb (
    .clk   (clk),
    .rst   (rst),
    .i_req (w_wv),
    .o_gnt (gnt_w),
    .o_idx (w_widx),
    .o_any (w_wany)
  );

  sl_rr_arb #(.NUM_M(NUM_M)) u_rarb (
    .clk   (clk),
    .rst   (rst),
    .i_req (w_rv),
    .o_gnt (gnt_r),
    .o_idx (w_ridx),
    .o_any (w_rany)
  );

  // Merge the granted write half and read half into one root beat.
  always_comb begin
    w_root = '0;
    if (w_wany) w_root.wreq = w_req[w_widx].wreq;
    if (w_rany) w_root.rreq = w_req[w_ridx].rreq;
  end

  assign w_res     = SL_RES'(res_root);
  assign w_tail    = r_tag[RD_LAT];
  assign w_deliver = w_res.rvalid && w_tail.valid;

  // Root beat, tag pipe, outstanding count, response steering and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_root <= '0;
      r_res  <= '{default: '0};
      r_tag  <= '{default: '0};
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_root <= w_root;
      r_tag[0] <= w_rany ? SL_RTAG'{valid: 1'b1, idx: SL_IDXW'(w_ridx)} : '0;
      for (int unsigned k = 1; k <= RD_LAT; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
      // Count covers slots 0..RD_LAT-1: a load enters, a move into the tail leaves.
      case ({w_rany, r_tag[RD_LAT-1].valid})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      for (int unsigned i = 0; i < NUM_M; i++) begin
        r_res[i] <= (w_deliver && (w_tail.idx == SL_IDXW'(i))) ? w_res : '0;
      end
      if (w_res.rvalid != w_tail.valid) r_err <= 1'b1;
    end
  end

  // Repack registered responses onto the flat output port.
  always_comb begin
    res_m = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      res_m[i*SW +: SW] = r_res[i];
    end
  end

  assign req_root       = r_root;
  assign rd_outstanding = r_cnt;
  assign lat_err        = r_err;

endmodule
